sig_lut_interp: RTL
===================

Name: sig_lut_interp

Overview:
Piecewise-linear activation stage that sits directly upstream of the layer's sigmoid LUT and consumes what it returns. It accepts a signed fixed-point pre-activation sample and splits it into a 4-bit LUT address and a fraction. It drives the address to the LUT, takes back the base and next entries, and produces the linearly interpolated activation. Fully pipelined, with a valid/ready handshake on both sides and a global stall under backpressure.

Parameters:
DATA_W, 8, width of signed input sample x.
ADDR_W, 4, LUT address width; address = x[DATA_W-1 -: ADDR_W], two's-complement segment index (0..7 = positive segments, 8..15 = negative segments).
FRAC_W, 4, fraction width; frac = x[FRAC_W-1:0], unsigned; DATA_W = ADDR_W + FRAC_W.
LUT_W, 8, signed width of LUT entries and of output y.

Ports:
clk  in  1  clock; all state on rising edge.
rst  in  1  asynchronous, active-high reset.
in_valid  in  1  input sample valid.
in_ready  out  1  stage can accept a sample.
in_x  in  DATA_W  signed pre-activation sample.
lut_address  out  ADDR_W  registered address to LUT.
lut_base  in  LUT_W  signed lut[address] (combinational return).
lut_next  in  LUT_W  signed next entry (LUT handles the 7->7 saturation and 15->0 zero-crossing wrap).
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts result.
out_y  out  LUT_W  signed interpolated activation.

Behaviour:
- Reset (async, immediate): all stage valids = 0, lut_address = 0, out_y = 0, out_valid = 0; in_ready = 1 once rst deasserts. A reset mid-operation discards every in-flight sample; no partial result emerges.
- stall = out_valid & ~out_ready; in_ready = ~stall (combinational). While stall is high, every pipeline register holds its value.
- Transfer rules:
  - Input transfer: in_valid & in_ready.
  - Output transfer: out_valid & out_ready.
- S0, on input transfer:
  - lut_address <= in_x[7:4]; frac0 <= in_x[3:0]; v0 <= 1.
  - Otherwise, when not stalled, v0 <= 0.
- S1:
  - Capture base1 = lut_base, next1 = lut_next, frac1 = frac0, v1 = v0.
  - lut_address stays stable while v0 is set and the pipeline is stalled, so the LUT return remains valid.
- S2:
  - diff = next1 - base1, 9-bit signed (sign-extend both operands first).
  - prod = diff * {1'b0, frac1}, 14-bit signed; base2 = base1; v2 = v1.
- S3 (output register):
  - sum = base2 + (prod >>> FRAC_W), arithmetic shift (floor).
  - Saturate sum to [-128, 127], then out_y <= sum; out_valid <= v2.
- Latency: result appears 3 cycles after the input transfer (registers S0, S1, S3, plus S2). Throughput: 1 sample/clock when out_ready = 1.
- Back-to-back and simultaneous events:
  - An input transfer and an output transfer in the same cycle both complete.
  - No bubble insertion and no sample loss or duplication.
- Boundary conditions:
  - frac = 0 gives y = base exactly.
  - Address 7 gives next = base, so y is flat.
  - Address 15 interpolates toward lut[0] across zero.
- out_y holds its last value while out_valid = 0.

Optional Feature:
SIG_INTERP_ROUND_EN:
- Defined: S3 computes base2 + ((prod + 2^(FRAC_W-1)) >>> FRAC_W), i.e. round half up.
- Undefined: truncating arithmetic shift (floor) as above.
- Latency and handshake are identical in both builds.

Decomposition:
- Shared package sig_nn_pkg holds:
  - constants DATA_W, ADDR_W, FRAC_W, LUT_W;
  - the types sample_t (signed DATA_W), lut_addr_t, frac_t, act_t (signed LUT_W);
  - saturation limits ACT_MAX = 127, ACT_MIN = -128.
- One natural sub-module, sig_interp_mac: the S2/S3 datapath (diff, multiply, shift/round, saturate) with a clock enable. Handshake and address staging stay in the top module.

Test Plan:
- Reset mid-stream: in-flight samples are discarded.
  - Stimulus: three samples in flight, assert rst for 1 cycle.
  - Response: out_valid = 0 and out_y = 0 immediately; no stale result afterwards; the next input yields its result 3 cycles after transfer.
- Single positive sample with LUT model (lut[0..15] = 8,11,14,15,15,15,15,15,0,0,0,0,0,0,1,4).
  - Stimulus: in_x = 0x08.
  - Response: out_y = 9 three cycles later (10 with SIG_INTERP_ROUND_EN).
  - Stimulus: in_x = 0x00.
  - Response: out_y = 8.
- Saturated and wrap segments, same LUT model.
  - in_x = 0x7F -> out_y = 15.
  - in_x = 0xF8 -> out_y = 6.
  - in_x = 0xE4 -> out_y = 1 (2 with SIG_INTERP_ROUND_EN).
  - in_x = 0x80 -> out_y = 0.
- Streaming: 16 consecutive samples with in_valid = 1 and out_ready = 1.
  - Response: 16 results on consecutive cycles, in order, matching the reference model.
- Backpressure: drop out_ready for 5 cycles mid-stream.
  - Response: in_ready = 0 during the stall; lut_address and out_y hold; no loss or duplication; output resumes in order.
- Saturation: drive lut_base = 127, lut_next = -128 via a forced LUT model.
  - Response: intermediate values stay in range; out_y is clamped within [-128, 127], with no wrap.

Source files
------------

// File: rtl/sig_nn_pkg.sv
// Shared types and constants for the sigmoid LUT interpolation stage.
package sig_nn_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int FRAC_W = 4;
  localparam int LUT_W  = 8;

  // diff needs one extra bit; prod = diff * unsigned frac (with a zero sign bit)
  localparam int DIFF_W = LUT_W + 1;
  localparam int PROD_W = DIFF_W + FRAC_W + 1;
  localparam int SUM_W  = PROD_W - FRAC_W + 1;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef logic        [ADDR_W-1:0] lut_addr_t;
  typedef logic        [FRAC_W-1:0] frac_t;
  typedef logic signed [LUT_W-1:0]  act_t;
  typedef logic signed [DIFF_W-1:0] diff_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [SUM_W-1:0]  sum_t;

  localparam act_t ACT_MAX = act_t'(127);
  localparam act_t ACT_MIN = act_t'(-128);

  typedef struct packed {
    act_t  base;
    act_t  nxt;
    frac_t frac;
  } lut_ret_t;

  function automatic act_t sat_act(input sum_t s);
    if (s > sum_t'(ACT_MAX))      return ACT_MAX;
    else if (s < sum_t'(ACT_MIN)) return ACT_MIN;
    else                          return act_t'(s);
  endfunction

endpackage

// File: rtl/sig_interp_mac.sv
// S2/S3 datapath: slope multiply, fractional shift (optional rounding), saturate.
// Build option: define SIG_INTERP_ROUND_EN for round-half-up instead of floor.
module sig_interp_mac
  import sig_nn_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_en,
  input  logic  i_valid,
  input  act_t  i_base,
  input  act_t  i_next,
  input  frac_t i_frac,
  output logic  o_valid,
  output act_t  o_y
);

  diff_t w_diff;
  prod_t w_prod;
  prod_t w_biased;
  prod_t w_shift;
  sum_t  w_sum;

  prod_t r_prod;
  act_t  r_base2;
  logic  r_v2;

  assign w_diff = diff_t'(i_next) - diff_t'(i_base);
  assign w_prod = prod_t'(w_diff) * prod_t'($signed({1'b0, i_frac}));

`ifdef SIG_INTERP_ROUND_EN
  assign w_biased = r_prod + prod_t'(2 ** (FRAC_W - 1));
`else
  assign w_biased = r_prod;
`endif

  assign w_shift = w_biased >>> FRAC_W;
  assign w_sum   = sum_t'(r_base2) + sum_t'(w_shift);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prod  <= '0;
      r_base2 <= '0;
      r_v2    <= 1'b0;
      o_valid <= 1'b0;
      o_y     <= '0;
    end else if (i_en) begin
      r_prod  <= w_prod;
      r_base2 <= i_base;
      r_v2    <= i_valid;
      o_valid <= r_v2;
      o_y     <= sat_act(w_sum);
    end
  end

endmodule

// File: rtl/sig_lut_interp.sv
// Sigmoid LUT interpolation stage: address split, LUT return capture, MAC.
// Build option: SIG_INTERP_ROUND_EN selects rounding in sig_interp_mac.
module sig_lut_interp
  import sig_nn_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      in_valid,
  output logic      in_ready,
  input  sample_t   in_x,
  output lut_addr_t lut_address,
  input  act_t      lut_base,
  input  act_t      lut_next,
  output logic      out_valid,
  input  logic      out_ready,
  output act_t      out_y
);

  logic     w_stall;
  logic     w_in_xfer;

  frac_t    r_frac0;
  logic     r_v0;
  lut_ret_t r_s1;
  logic     r_v1;

  // Global stall: every stage freezes together, so the LUT address (and
  // therefore its combinational return) stays stable for a held S0 sample.
  assign w_stall   = out_valid & ~out_ready;
  assign in_ready  = ~w_stall;
  assign w_in_xfer = in_valid & in_ready;

  // NOTE: datapath registers are reset along with the valids so out_y and
  // lut_address come up at zero rather than X.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lut_address <= '0;
      r_frac0     <= '0;
      r_v0        <= 1'b0;
      r_s1        <= '0;
      r_v1        <= 1'b0;
    end else if (!w_stall) begin
      r_v0 <= w_in_xfer;
      if (w_in_xfer) begin
        lut_address <= in_x[DATA_W-1 -: ADDR_W];
        r_frac0     <= in_x[FRAC_W-1:0];
      end
      r_s1.base <= lut_base;
      r_s1.nxt  <= lut_next;
      r_s1.frac <= r_frac0;
      r_v1      <= r_v0;
    end
  end

  sig_interp_mac u_mac (
    .clk     (clk),
    .rst     (rst),
    .i_en    (~w_stall),
    .i_valid (r_v1),
    .i_base  (r_s1.base),
    .i_next  (r_s1.nxt),
    .i_frac  (r_s1.frac),
    .o_valid (out_valid),
    .o_y     (out_y)
  );

endmodule
